// File: rtl/wb_pkg.sv
// Shared defaults and types for the write-back buffer and its forwarding matcher.
package wb_pkg;
    localparam int WB_AW = 5;
    localparam int WB_DW = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Priority search over the pending entries: walks them oldest to youngest
// so the youngest match overrides older ones.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][AW-1:0] addr_i,
    input  logic [DEPTH-1:0][DW-1:0] data_i,
    input  logic [PW-1:0]            head_i,
    input  logic [PW:0]              count_i,
    input  logic [AW-1:0]            key_i,
    output logic                     hit_o,
    output logic [DW-1:0]            data_o
);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (CW'(k) < count_i && addr_i[idx] == key_i && key_i != AW'(REG_ZERO)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/writeback_buffer.sv
// In-order write-back queue in front of the register file; ALU beats memory.
// Forwarding lookup is built only when WB_FORWARD_EN is defined.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          rf_hold,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     full, alu_fire, mem_fire, store, pop;
    logic [AW-1:0]            in_addr;
    logic [DW-1:0]            in_data;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign alu_ready = ~full;
    // Held low during reset so the memory side never sees a phantom handshake.
    assign mem_ready = reset & ~full & ~alu_valid;

    assign alu_fire = alu_valid & alu_ready;
    assign mem_fire = mem_valid & mem_ready;
    assign in_addr  = alu_fire ? alu_addr : mem_addr;
    assign in_data  = alu_fire ? alu_data : mem_data;
    // r0 writes complete the handshake but are discarded.
    assign store    = (alu_fire | mem_fire) & (in_addr != AW'(REG_ZERO));

    assign rf_we   = ~empty & ~rf_hold;
    assign pop     = rf_we;
    assign rf_addr = empty ? '0 : addr_q[head_q];
    assign rf_data = empty ? '0 : data_q[head_q];

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(store);
        count_d = count_q + CW'(store) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

`ifdef WB_FORWARD_EN
    wb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_fwd (
        .addr_i  (addr_q),
        .data_i  (data_q),
        .head_i  (head_q),
        .count_i (count_q),
        .key_i   (fwd_addr),
        .hit_o   (fwd_hit),
        .data_o  (fwd_data)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed plus randomized bench for writeback_buffer against a queue model.
module tb_writeback_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0, rf_hold = 1'b0;
    logic [AW-1:0] alu_addr = '0, mem_addr = '0, fwd_addr = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, rf_we, fwd_hit, empty;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data, fwd_data;

    int        checks = 0;
    int        errors = 0;
    wb_entry_t q[$];
    logic      mem_took = 1'b0;

    writeback_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_hold(rf_hold), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the queue contents and the current inputs.
    task automatic check_all(input string tag);
        logic        eh;
        logic [31:0] ed;
        int          n;
        n  = q.size();
        eh = 1'b0;
        ed = '0;
`ifdef WB_FORWARD_EN
        if (fwd_addr != 0)
            foreach (q[i]) if (q[i].addr == fwd_addr) begin eh = 1'b1; ed = q[i].data; end
`endif
        chk({tag, ":empty"},     32'(empty),     32'(n == 0));
        chk({tag, ":alu_ready"}, 32'(alu_ready), 32'(n != DEPTH));
        chk({tag, ":mem_ready"}, 32'(mem_ready), 32'(reset && n != DEPTH && !alu_valid));
        chk({tag, ":rf_we"},     32'(rf_we),     32'(n != 0 && !rf_hold));
        chk({tag, ":rf_addr"},   32'(rf_addr),   (n != 0) ? 32'(q[0].addr) : 32'd0);
        chk({tag, ":rf_data"},   rf_data,        (n != 0) ? q[0].data : 32'd0);
        chk({tag, ":fwd_hit"},   32'(fwd_hit),   32'(eh));
        chk({tag, ":fwd_data"},  fwd_data,       ed);
    endtask

    // Advance one edge and apply the handshake rules to the model.
    task automatic tick();
        logic      afire, mfire, pop;
        wb_entry_t e;
        afire  = alu_valid && q.size() != DEPTH;
        mfire  = reset && mem_valid && q.size() != DEPTH && !alu_valid;
        pop    = q.size() != 0 && !rf_hold;
        e.addr = afire ? alu_addr : mem_addr;
        e.data = afire ? alu_data : mem_data;
        @(posedge clock);
        if (reset) begin
            if (pop) void'(q.pop_front());
            if ((afire || mfire) && e.addr != 0) q.push_back(e);
        end
        mem_took = mfire;
        #1;
    endtask

    task automatic step(input string tag);
        #2;
        check_all(tag);
        tick();
    endtask

    task automatic drain();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rf_hold   = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step("drain");
    endtask

    initial begin
        // Reset state
        #2;
        check_all("rst");
        chk("rst:mem_ready0", 32'(mem_ready), 32'd0);
        chk("rst:alu_ready1", 32'(alu_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
        step("alu1");
        alu_valid = 1'b0;
        #2;
        check_all("alu1_c2");
        chk("alu1:we",   32'(rf_we),   32'd1);
        chk("alu1:addr", 32'(rf_addr), 32'd3);
        chk("alu1:data", rf_data,      32'hDEADBEEF);
        tick();
        #2;
        chk("alu1:empty", 32'(empty), 32'd1);
        tick();

        // Register-zero drop
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
        #2;
        chk("r0:ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #2;
        check_all("r0");
        chk("r0:we",    32'(rf_we), 32'd0);
        chk("r0:empty", 32'(empty), 32'd1);
        tick();

        // Arbitration: ALU wins, memory holds its offer
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h22;
        #2;
        check_all("arb0");
        chk("arb:mem_ready0", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        #2;
        check_all("arb1");
        chk("arb:first", 32'(rf_addr), 32'd5);
        tick();
        mem_valid = 1'b0;
        #2;
        check_all("arb2");
        chk("arb:second", 32'(rf_addr), 32'd7);
        tick();
        drain();

        // Full / backpressure
        rf_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            alu_valid = 1'b1; alu_addr = AW'(i + 1); alu_data = 32'hA1 + 32'(i);
            step("fill");
        end
        alu_valid = 1'b0;
        #2;
        check_all("full");
        chk("full:alu_ready0", 32'(alu_ready), 32'd0);
        rf_hold = 1'b0;
        #1;
        chk("full:ready_at_pop", 32'(alu_ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check_all("unload");
            chk("unload:addr", 32'(rf_addr), 32'(i + 1));
            chk("unload:data", rf_data, 32'hA1 + 32'(i));
            tick();
            #2;
            chk("unload:ready", 32'(alu_ready), 32'd1);
        end
        chk("unload:empty", 32'(empty), 32'd1);
        tick();

        // Forwarding (youngest match, r0 never hits)
        rf_hold = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h10;
        step("fwd_p1");
        alu_data = 32'h20;
        step("fwd_p2");
        alu_valid = 1'b0;
        fwd_addr  = 5'd6;
        #2;
        check_all("fwd6");
`ifdef WB_FORWARD_EN
        chk("fwd:hit",  32'(fwd_hit), 32'd1);
        chk("fwd:data", fwd_data,     32'h20);
`else
        chk("fwd:tied_hit", 32'(fwd_hit), 32'd0);
`endif
        fwd_addr = 5'd0;
        #1;
        check_all("fwd0");
        chk("fwd0:hit", 32'(fwd_hit), 32'd0);
        tick();
        drain();

        // Reset mid-operation
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_addr = AW'(i + 9); alu_data = 32'hC0 + 32'(i);
            step("pre_rst");
        end
        alu_valid = 1'b0;
        rf_hold   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst:we",    32'(rf_we), 32'd0);
        chk("midrst:empty", 32'(empty), 32'd1);
        q.delete();
        check_all("midrst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("postrst:we", 32'(rf_we), 32'd0);
            check_all("postrst");
            tick();
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_addr  = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
            if (!(mem_valid && !mem_took)) begin
                mem_valid = ($urandom_range(0, 1) == 1);
                mem_addr  = AW'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            rf_hold  = ($urandom_range(0, 3) == 0);
            fwd_addr = AW'($urandom_range(0, 7));
            step("rnd");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
